reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NUM_CH, default 4: number of staged reset channels; legal range 1..16.
REQ-002 Parameter HOLD_CYCLES, default 50: CLK cycles the HOLD state lasts; must be >= 1.
REQ-003 Parameter LOCK_STABLE, default 4: consecutive cycles with all locked bits high required before release; must be >= 1.
REQ-004 Parameter STAGE_GAP, default 8: CLK cycles between successive channel releases; must be >= 1.
REQ-005 Parameter CNT_W, default 16: counter width; must hold max(HOLD_CYCLES, LOCK_STABLE, STAGE_GAP).
REQ-006 CLK  input  1  sole clock (100 MHz nominal); all logic on its rising edge.
REQ-007 RESET  input  1  asynchronous, active-low reset.
REQ-008 locked  input  NUM_CH  per-channel clock-ready flags, already synchronous to CLK.
REQ-009 soft_rst  input  1  synchronous active-high restart request.
REQ-010 rst_n_out  output  NUM_CH  per-channel active-low reset, registered.
REQ-011 seq_done  output  1  high while all channels are released.
REQ-012 lock_lost  output  1  one-cycle pulse on abort caused by a locked bit falling.
REQ-013 state  output  2  current FSM state: HOLD=0, WAIT_LOCK=1, RELEASE=2, DONE=3.

Function
REQ-014 FSM states: HOLD, WAIT_LOCK, RELEASE, DONE; one cycle counter (CNT_W bits) and one channel index register.
REQ-015 HOLD: counter increments each edge; on the edge where counter == HOLD_CYCLES-1, go to WAIT_LOCK and clear counter; HOLD therefore lasts exactly HOLD_CYCLES edges.
REQ-016 WAIT_LOCK: counter increments on each edge with &locked == 1 and clears to 0 on any edge with &locked == 0.
REQ-017 WAIT_LOCK exit: on the edge where &locked == 1 and counter == LOCK_STABLE-1, set rst_n_out[0]=1, set index=0, clear counter, go to RELEASE (or DONE if NUM_CH == 1).
REQ-018 RELEASE: counter increments each edge; when counter == STAGE_GAP-1, increment index, set rst_n_out[index+1]=1 and clear counter.
REQ-019 Release order: channel k is released exactly STAGE_GAP edges after channel k-1; released bits stay high until abort or reset.
REQ-020 On the edge that releases channel NUM_CH-1, go to DONE and set seq_done=1 on that same edge.
REQ-021 DONE: hold all rst_n_out high and seq_done high; counter idle.
REQ-022 Lock abort: in RELEASE or DONE, any edge with &locked == 0 does three things on that edge: drive rst_n_out to all-0, clear seq_done, and go to HOLD with counter and index cleared.
REQ-023 Lock abort pulse: on that same edge, lock_lost=1 for exactly one cycle.
REQ-024 A lock drop in HOLD or WAIT_LOCK never asserts lock_lost.
REQ-025 soft_rst: on any edge with soft_rst == 1, in any state, drive rst_n_out to all-0, clear seq_done, clear counter and index, and enter HOLD; lock_lost=0.
REQ-026 Priority when several conditions hold on one edge: soft_rst, then lock abort, then normal progression.
REQ-027 soft_rst held high keeps the block in HOLD with counter 0; counting starts on the first edge after soft_rst falls.
REQ-028 An output bit of rst_n_out never toggles 0->1 except by the release rule in REQ-018/REQ-019; no glitches, all outputs registered.

Reset
REQ-029 RESET low asynchronously forces state=HOLD, counter=0, index=0, rst_n_out=all 0, seq_done=0, lock_lost=0.
REQ-030 The first rising CLK edge with RESET high is HOLD edge 1; RESET asserted mid-sequence aborts immediately with the same values as REQ-029.

Verification
REQ-031 Defaults, locked=4'hF constant, RESET released before edge 1 -> state=1 after edge 50; rst_n_out=4'b0001 at edge 54; 4'b0011 at 62; 4'b0111 at 70; 4'b1111 and seq_done=1 at 78.
REQ-032 Defaults, locked[2] low until edge 60, then high -> WAIT_LOCK counter clears each cycle; rst_n_out[0] rises at edge 63; seq_done=1 at edge 87.
REQ-033 In DONE, drop locked[1] for one cycle -> rst_n_out=4'b0000, seq_done=0, lock_lost=1 for exactly one cycle, state=0; full sequence replays.
REQ-034 At edge 66 (RELEASE, 4'b0011), assert soft_rst together with locked[3] falling -> outputs to 0, state=0, lock_lost stays 0.
REQ-035 NUM_CH=1, HOLD_CYCLES=1, LOCK_STABLE=1 -> rst_n_out[0] and seq_done rise at edge 2; RESET pulsed low mid-DONE -> all outputs 0 asynchronously, before the next edge.

Source files
------------

// File: rtl/reset_sequencer.sv
// Staged reset release: hold, wait for stable clock locks, then
// release each channel's active-low reset one gap apart.
module reset_sequencer #(
    parameter int NUM_CH      = 4,
    parameter int HOLD_CYCLES = 50,
    parameter int LOCK_STABLE = 4,
    parameter int STAGE_GAP   = 8,
    parameter int CNT_W       = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] locked,
    input  logic              soft_rst,
    output logic [NUM_CH-1:0] rst_n_out,
    output logic              seq_done,
    output logic              lock_lost,
    output logic [1:0]        state
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        WAIT_LOCK = 2'd1,
        RELEASE   = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [NUM_CH-1:0] rst_q, rst_d;
    logic              done_q, done_d;
    logic              lost_q, lost_d;

    logic              all_locked;
    logic [IDX_W-1:0]  idx_inc;

    assign all_locked = &locked;
    assign idx_inc    = idx_q + IDX_W'(1);

    // State and output registers; RESET clears everything at once
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '0;
            done_q  <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
            lost_q  <= lost_d;
        end
    end

    // Next state: soft restart beats lock abort beats normal progress
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        done_d  = done_q;
        lost_d  = 1'b0;
        if (soft_rst) begin
            state_d = HOLD;
            cnt_d   = '0;
            idx_d   = '0;
            rst_d   = '0;
            done_d  = 1'b0;
        end else if ((state_q == RELEASE || state_q == DONE)
                     && !all_locked) begin
            state_d = HOLD;
            cnt_d   = '0;
            idx_d   = '0;
            rst_d   = '0;
            done_d  = 1'b0;
            lost_d  = 1'b1;
        end else begin
            case (state_q)
                HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d   = '0;
                        state_d = WAIT_LOCK;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (!all_locked) begin
                        cnt_d = '0;
                    end else if (cnt_q == LOCK_LAST) begin
                        cnt_d    = '0;
                        idx_d    = '0;
                        rst_d[0] = 1'b1;
                        if (NUM_CH == 1) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d = '0;
                        idx_d = idx_inc;
                        rst_d = rst_q | (NUM_CH'(1) << idx_inc);
                        if (idx_inc == LAST_IDX) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs come straight from registers so they cannot glitch
    always_comb begin
        rst_n_out = rst_q;
        seq_done  = done_q;
        lock_lost = lost_q;
        state     = state_q;
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed vector table, randomized
// traffic against an event-time reference model, 1-channel corner.
module tb_reset_sequencer;

    localparam int NCH  = 4;
    localparam int HOLD = 50;
    localparam int LOCK = 4;
    localparam int GAP  = 8;

    logic           CLK;
    logic           RESET;
    logic [NCH-1:0] locked;
    logic           soft_rst;
    logic [NCH-1:0] rst_n_out;
    logic           seq_done;
    logic           lock_lost;
    logic [1:0]     state;

    logic           RESET1;
    logic [0:0]     locked1;
    logic           soft1;
    logic [0:0]     rst1;
    logic           done1;
    logic           lost1;
    logic [1:0]     state1;

    int tests;
    int fails;

    reset_sequencer dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .locked   (locked),
        .soft_rst (soft_rst),
        .rst_n_out(rst_n_out),
        .seq_done (seq_done),
        .lock_lost(lock_lost),
        .state    (state)
    );

    reset_sequencer #(
        .NUM_CH     (1),
        .HOLD_CYCLES(1),
        .LOCK_STABLE(1)
    ) dut1 (
        .CLK      (CLK),
        .RESET    (RESET1),
        .locked   (locked1),
        .soft_rst (soft1),
        .rst_n_out(rst1),
        .seq_done (done1),
        .lock_lost(lost1),
        .state    (state1)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Reference model: edge numbers of events, not a state machine.
    // seg = first HOLD edge, t0 = edge that released channel 0.
    int n;
    int seg;
    int t0;
    int streak;
    bit mlost;

    function automatic void model_reset();
        seg    = n + 1;
        t0     = 0;
        streak = 0;
        mlost  = 1'b0;
    endfunction

    function automatic void model_step(logic [NCH-1:0] lk, logic sr);
        bit all;
        all   = (lk == '1);
        mlost = 1'b0;
        if (sr) begin
            model_reset();
        end else if (t0 != 0 && !all) begin
            model_reset();
            mlost = 1'b1;
        end else if (t0 == 0 && n >= seg + HOLD) begin
            streak = all ? streak + 1 : 0;
            if (streak == LOCK) t0 = n;
        end
    endfunction

    task automatic expect_vals(output logic [1:0] st,
                               output logic [3:0] rn,
                               output logic dn, output logic ll);
        int k;
        ll = mlost;
        if (t0 != 0) begin
            k  = (n - t0) / GAP + 1;
            if (k > NCH) k = NCH;
            rn = 4'((1 << k) - 1);
            dn = (k == NCH);
            st = dn ? 2'd3 : 2'd2;
        end else begin
            rn = '0;
            dn = 1'b0;
            st = (n >= seg + HOLD - 1) ? 2'd1 : 2'd0;
        end
    endtask

    task automatic chk(string nm, logic [1:0] st, logic [3:0] rn,
                       logic dn, logic ll);
        tests++;
        if ({state, rst_n_out, seq_done, lock_lost} !== {st, rn, dn, ll}) begin
            fails++;
            $display("FAIL %s edge %0d: got st=%0d rn=%b dn=%b ll=%b, want st=%0d rn=%b dn=%b ll=%b",
                     nm, n, state, rst_n_out, seq_done, lock_lost,
                     st, rn, dn, ll);
        end
    endtask

    task automatic step();
        logic [1:0] st;
        logic [3:0] rn;
        logic       dn;
        logic       ll;
        @(posedge CLK);
        n++;
        model_step(locked, soft_rst);
        #1;
        expect_vals(st, rn, dn, ll);
        chk("model", st, rn, dn, ll);
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        #2;
        chk("async_reset", 2'd0, 4'b0000, 1'b0, 1'b0);
        model_reset();
        RESET = 1'b1;
    endtask

    typedef struct {
        bit         rs;
        int         cyc;
        logic [3:0] lk;
        logic       sr;
        logic [1:0] st;
        logic [3:0] rn;
        logic       dn;
        logic       ll;
    } row_t;

    row_t tbl[$];

    initial begin
        tests    = 0;
        fails    = 0;
        n        = 0;
        RESET    = 1'b0;
        locked   = '1;
        soft_rst = 1'b0;
        RESET1   = 1'b0;
        locked1  = 1'b1;
        soft1    = 1'b0;
        model_reset();

        // Nominal sequence, DONE abort by locked[1], full replay
        tbl.push_back('{1, 49, 4'hF, 0, 2'd0, 4'b0000, 0, 0});
        tbl.push_back('{0, 1,  4'hF, 0, 2'd1, 4'b0000, 0, 0});
        tbl.push_back('{0, 3,  4'hF, 0, 2'd1, 4'b0000, 0, 0});
        tbl.push_back('{0, 1,  4'hF, 0, 2'd2, 4'b0001, 0, 0});
        tbl.push_back('{0, 7,  4'hF, 0, 2'd2, 4'b0001, 0, 0});
        tbl.push_back('{0, 1,  4'hF, 0, 2'd2, 4'b0011, 0, 0});
        tbl.push_back('{0, 8,  4'hF, 0, 2'd2, 4'b0111, 0, 0});
        tbl.push_back('{0, 7,  4'hF, 0, 2'd2, 4'b0111, 0, 0});
        tbl.push_back('{0, 1,  4'hF, 0, 2'd3, 4'b1111, 1, 0});
        tbl.push_back('{0, 5,  4'hF, 0, 2'd3, 4'b1111, 1, 0});
        tbl.push_back('{0, 1,  4'hD, 0, 2'd0, 4'b0000, 0, 1});
        tbl.push_back('{0, 1,  4'hF, 0, 2'd0, 4'b0000, 0, 0});
        tbl.push_back('{0, 49, 4'hF, 0, 2'd1, 4'b0000, 0, 0});
        tbl.push_back('{0, 4,  4'hF, 0, 2'd2, 4'b0001, 0, 0});
        tbl.push_back('{0, 24, 4'hF, 0, 2'd3, 4'b1111, 1, 0});
        // locked[2] low through edge 59
        tbl.push_back('{1, 50, 4'hB, 0, 2'd1, 4'b0000, 0, 0});
        tbl.push_back('{0, 9,  4'hB, 0, 2'd1, 4'b0000, 0, 0});
        tbl.push_back('{0, 3,  4'hF, 0, 2'd1, 4'b0000, 0, 0});
        tbl.push_back('{0, 1,  4'hF, 0, 2'd2, 4'b0001, 0, 0});
        tbl.push_back('{0, 23, 4'hF, 0, 2'd2, 4'b0111, 0, 0});
        tbl.push_back('{0, 1,  4'hF, 0, 2'd3, 4'b1111, 1, 0});
        // soft_rst with locked[3] falling at edge 66, then held
        tbl.push_back('{1, 62, 4'hF, 0, 2'd2, 4'b0011, 0, 0});
        tbl.push_back('{0, 3,  4'hF, 0, 2'd2, 4'b0011, 0, 0});
        tbl.push_back('{0, 1,  4'h7, 1, 2'd0, 4'b0000, 0, 0});
        tbl.push_back('{0, 5,  4'hF, 1, 2'd0, 4'b0000, 0, 0});
        tbl.push_back('{0, 49, 4'hF, 0, 2'd0, 4'b0000, 0, 0});
        tbl.push_back('{0, 1,  4'hF, 0, 2'd1, 4'b0000, 0, 0});

        foreach (tbl[r]) begin
            if (tbl[r].rs) begin
                n = 0;
                do_reset();
            end
            locked   = tbl[r].lk;
            soft_rst = tbl[r].sr;
            for (int c = 0; c < tbl[r].cyc; c++) step();
            chk($sformatf("row%0d", r), tbl[r].st, tbl[r].rn,
                tbl[r].dn, tbl[r].ll);
        end

        // Randomized traffic against the model
        soft_rst = 1'b0;
        locked   = '1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            locked   = ($urandom_range(0, 99) == 0) ? 4'($urandom) : 4'hF;
            soft_rst = ($urandom_range(0, 299) == 0);
            step();
        end
        locked   = '1;
        soft_rst = 1'b0;

        // Single channel, minimal timing, async reset in DONE
        RESET1 = 1'b1;
        step();
        tests++;
        if ({state1, rst1, done1, lost1} !== {2'd1, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL ch1_edge1: got st=%0d rn=%b dn=%b ll=%b, want st=1 rn=0 dn=0 ll=0",
                     state1, rst1, done1, lost1);
        end
        step();
        tests++;
        if ({state1, rst1, done1, lost1} !== {2'd3, 1'b1, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL ch1_edge2: got st=%0d rn=%b dn=%b ll=%b, want st=3 rn=1 dn=1 ll=0",
                     state1, rst1, done1, lost1);
        end
        #2;
        RESET1 = 1'b0;
        #1;
        tests++;
        if ({state1, rst1, done1, lost1} !== {2'd0, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL ch1_async: got st=%0d rn=%b dn=%b ll=%b, want all 0",
                     state1, rst1, done1, lost1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
